// File: rtl/ram_param.sv
// Parametrised single-port register RAM with registered read, selectable
// read-during-write behaviour and a post-reset clear sweep.
module ram_param #(
  parameter int               WIDTH       = 16,
  parameter int               ADDR_W      = 3,
  parameter bit               WRITE_FIRST = 1'b1,
  parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  in,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  output logic [WIDTH-1:0]  out,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DEPTH - 1);

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [0:0]        state;
  logic [ADDR_W:0]   clr_ptr;

  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [WIDTH-1:0]  wd;

  assign busy = (state == CLEAR);

  // The sweep and normal writes share one array port; the sweep has priority.
  always_comb begin
    we = 1'b0;
    wa = address;
    wd = in;
    if (!reset) begin
      if (state == CLEAR) begin
        we = 1'b1;
        wa = clr_ptr[ADDR_W-1:0];
        wd = CLEAR_VALUE;
      end else if (load) begin
        we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out     <= '0;
      state   <= CLEAR;
      clr_ptr <= '0;
    end else if (state == CLEAR) begin
      out     <= '0;
      clr_ptr <= clr_ptr + (ADDR_W + 1)'(1);
      if (clr_ptr == LAST) state <= RUN;
    end else begin
      if (load && WRITE_FIRST) out <= in;
      else                     out <= mem[address];
    end
  end

endmodule

// File: tb/tb_ram_param.sv
// Self-checking bench for ram_param: write-first, read-first and a wide/deep
// build, checked every cycle against a behavioural model plus directed literals.
module tb_ram_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [2:0]  address;
  logic [15:0] din;
  logic        load_c;
  logic [4:0]  addr_c;
  logic [7:0]  din_c;

  logic [15:0] out_a, out_b;
  logic        busy_a, busy_b;
  logic [7:0]  out_c;
  logic        busy_c;

  localparam logic [15:0] CV_AB = 16'h00A5;
  localparam logic [7:0]  CV_C  = 8'h3C;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ram_param #(.WIDTH(16), .ADDR_W(3), .WRITE_FIRST(1'b1), .CLEAR_VALUE(CV_AB)) dut_a (
    .clk(clk), .reset(reset), .in(din), .load(load), .address(address),
    .out(out_a), .busy(busy_a));

  ram_param #(.WIDTH(16), .ADDR_W(3), .WRITE_FIRST(1'b0), .CLEAR_VALUE(CV_AB)) dut_b (
    .clk(clk), .reset(reset), .in(din), .load(load), .address(address),
    .out(out_b), .busy(busy_b));

  ram_param #(.WIDTH(8), .ADDR_W(5), .WRITE_FIRST(1'b1), .CLEAR_VALUE(CV_C)) dut_c (
    .clk(clk), .reset(reset), .in(din_c), .load(load_c), .address(addr_c),
    .out(out_c), .busy(busy_c));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: after any reset edge the memory is unusable for DEPTH further edges,
  // then every word equals the clear value; afterwards it is a plain array.
  logic [15:0] m_mem [8];
  int          remain_ab = 0;
  bit          valid_ab  = 0;
  logic [15:0] m_out_a, m_out_b, old_ab;
  logic        m_busy_ab;

  always @(posedge clk) begin
    if (reset) begin
      valid_ab  = 1;
      remain_ab = 8;
      m_out_a   = '0;
      m_out_b   = '0;
      m_busy_ab = 1'b1;
    end else if (valid_ab) begin
      if (remain_ab > 0) begin
        remain_ab--;
        m_out_a = '0;
        m_out_b = '0;
        if (remain_ab == 0) begin
          foreach (m_mem[i]) m_mem[i] = CV_AB;
          m_busy_ab = 1'b0;
        end
      end else begin
        old_ab = m_mem[address];
        if (load) m_mem[address] = din;
        m_out_a = load ? din : old_ab;
        m_out_b = old_ab;
      end
    end
  end

  logic [7:0] m_mem_c [32];
  int         remain_c = 0;
  bit         valid_c  = 0;
  logic [7:0] m_out_c, old_c;
  logic       m_busy_c;

  always @(posedge clk) begin
    if (reset) begin
      valid_c  = 1;
      remain_c = 32;
      m_out_c  = '0;
      m_busy_c = 1'b1;
    end else if (valid_c) begin
      if (remain_c > 0) begin
        remain_c--;
        m_out_c = '0;
        if (remain_c == 0) begin
          foreach (m_mem_c[i]) m_mem_c[i] = CV_C;
          m_busy_c = 1'b0;
        end
      end else begin
        old_c = m_mem_c[addr_c];
        if (load_c) m_mem_c[addr_c] = din_c;
        m_out_c = load_c ? din_c : old_c;
      end
    end
  end

  always @(negedge clk) begin
    if (valid_ab) begin
      chk("model out_a", 32'(out_a), 32'(m_out_a));
      chk("model out_b", 32'(out_b), 32'(m_out_b));
      chk("model busy_a", 32'(busy_a), 32'(m_busy_ab));
      chk("model busy_b", 32'(busy_b), 32'(m_busy_ab));
    end
    if (valid_c) begin
      chk("model out_c", 32'(out_c), 32'(m_out_c));
      chk("model busy_c", 32'(busy_c), 32'(m_busy_c));
    end
  end

  task automatic step(input logic r, input logic ld, input logic [2:0] a, input logic [15:0] d);
    reset   = r;
    load    = ld;
    address = a;
    din     = d;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    load_c = 1'b0;
    addr_c = '0;
    din_c  = '0;

    // 1: reset two cycles, sweep, read back clear value
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("reset busy_a", 32'(busy_a), 32'd1);
    chk("reset out_a", 32'(out_a), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      step(0, 0, 0, 0);
      chk("sweep busy_a", 32'(busy_a), (k < 8) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 3'(i), 0);
      chk("clear read a", 32'(out_a), 32'h00A5);
      chk("clear read b", 32'(out_b), 32'h00A5);
    end

    // 2: write then read all addresses
    for (int i = 0; i < 8; i++) step(0, 1, 3'(i), 16'h1000 + 16'(i));
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 3'(i), 16'hFFFF);
      chk("rw read a", 32'(out_a), 32'h1000 + 32'(i));
      chk("rw read b", 32'(out_b), 32'h1000 + 32'(i));
    end

    // 3: read during write
    step(0, 1, 3, 16'hBEEF);
    step(0, 1, 3, 16'hCAFE);
    chk("rdw write_first", 32'(out_a), 32'hCAFE);
    chk("rdw read_first", 32'(out_b), 32'hBEEF);
    step(0, 0, 3, 0);
    chk("rdw after a", 32'(out_a), 32'hCAFE);
    chk("rdw after b", 32'(out_b), 32'hCAFE);

    // 4: writes ignored while busy
    step(1, 0, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      step(0, 1, 5, 16'h1234);
      chk("busy write out", 32'(out_a), 32'd0);
    end
    chk("busy write busy", 32'(busy_a), 32'd0);
    step(0, 0, 5, 0);
    chk("busy write ignored", 32'(out_a), 32'h00A5);

    // 5: reset on the 4th sweep edge restarts the sweep
    step(1, 0, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("mid reset busy", 32'(busy_a), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      step(0, 0, 0, 0);
      chk("restart busy", 32'(busy_a), (k < 8) ? 32'd1 : 32'd0);
    end
    step(0, 1, 7, 16'hFFFF);
    step(1, 0, 0, 0);
    for (int k = 0; k < 8; k++) step(0, 0, 0, 0);
    step(0, 0, 7, 0);
    chk("run reset clears a", 32'(out_a), 32'h00A5);
    chk("run reset clears b", 32'(out_b), 32'h00A5);

    // 6: WIDTH=8, ADDR_W=5 build
    step(1, 0, 0, 0);
    for (int k = 1; k <= 32; k++) begin
      step(0, 0, 0, 0);
      if (k == 31 || k == 32) chk("deep busy", 32'(busy_c), (k < 32) ? 32'd1 : 32'd0);
    end
    load_c = 1'b1; addr_c = 5'd31; din_c = 8'h5A;
    step(0, 0, 0, 0);
    load_c = 1'b0; addr_c = 5'd31; din_c = 8'h00;
    step(0, 0, 0, 0);
    chk("deep read 31", 32'(out_c), 32'h5A);
    addr_c = 5'd0;
    step(0, 0, 0, 0);
    chk("deep read 0", 32'(out_c), 32'h3C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
